// File: rtl/alu_operation_sequencer.sv
// Sequences one 6502 ALU operation per request: input-register load, ALU settle
// window, optional BCD adjust, then a valid/ready result handshake.
module alu_operation_sequencer #(
  parameter int EXEC_CYCLES     = 1,
  parameter int DECIMAL_SUPPORT = 1
) (
  input  logic       clk,
  input  logic       reset_N,
  input  logic       req_VALID,
  output logic       req_READY,
  input  logic [2:0] req_OP,
  input  logic       req_A_ZERO,
  input  logic       req_CARRY_IN,
  input  logic       req_DECIMAL,
  output logic       aInput_systemBus_EN,
  output logic       aInput_zero_EN,
  output logic       bInput_dataBus_EN,
  output logic       bInput_invert_EN,
  output logic [2:0] alu_OP,
  output logic       alu_CARRY_IN,
  input  logic [7:0] alu_RESULT,
  input  logic       alu_CARRY_OUT,
  input  logic       alu_OVERFLOW,
  input  logic       alu_HALFCARRY,
  output logic [7:0] result_DATA,
  output logic       result_CARRY,
  output logic       result_OVERFLOW,
  output logic       result_ERROR,
  output logic       result_VALID,
  input  logic       result_READY
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_ADJUST, S_DONE} state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t     r_state, w_state;
  logic [2:0] r_op, w_op;
  logic       r_cin, w_cin;
  logic       r_dec, w_dec;
  logic [3:0] r_cnt, w_cnt;
  logic       r_a_bus_en, w_a_bus_en;
  logic       r_a_zero_en, w_a_zero_en;
  logic       r_b_en, w_b_en;
  logic       r_b_inv_en, w_b_inv_en;
  logic [2:0] r_alu_op, w_alu_op;
  logic       r_alu_cin, w_alu_cin;
  logic [7:0] r_res, w_res;
  logic       r_c, w_c;
  logic       r_v, w_v;
  logic       r_h, w_h;
  logic       r_err, w_err;
  logic       r_valid, w_valid;
  logic [7:0] w_adj;
  logic       w_bcd;

  assign w_bcd = (DECIMAL_SUPPORT != 0) && r_dec && ((r_op == OP_ADD) || (r_op == OP_SUB));

  always_comb begin
    // NOTE: every w_ signal gets a default first so no path through the case can infer a latch.
    w_state     = r_state;
    w_op        = r_op;
    w_cin       = r_cin;
    w_dec       = r_dec;
    w_cnt       = r_cnt;
    w_a_bus_en  = 1'b0;
    w_a_zero_en = 1'b0;
    w_b_en      = 1'b0;
    w_b_inv_en  = 1'b0;
    w_alu_op    = 3'd0;
    w_alu_cin   = 1'b0;
    w_res       = r_res;
    w_c         = r_c;
    w_v         = r_v;
    w_h         = r_h;
    w_err       = r_err;
    w_valid     = 1'b0;
    w_adj       = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (req_VALID) begin
          w_op  = req_OP;
          w_cin = req_CARRY_IN;
          w_dec = req_DECIMAL;
          if (req_OP > OP_SUB) begin
            w_state = S_DONE;
            w_res   = 8'h00;
            w_c     = 1'b0;
            w_v     = 1'b0;
            w_err   = 1'b1;
            w_valid = 1'b1;
          end else begin
            // Enables are registered here so the transparent input latches see clean pulses during LOAD.
            w_state     = S_LOAD;
            w_err       = 1'b0;
            w_a_bus_en  = !req_A_ZERO;
            w_a_zero_en = req_A_ZERO;
            w_b_en      = 1'b1;
            w_b_inv_en  = (req_OP == OP_SUB);
          end
        end
      end
      S_LOAD: begin
        w_state   = S_EXEC;
        w_cnt     = 4'd0;
        w_alu_op  = (r_op == OP_SUB) ? OP_ADD : r_op;
        w_alu_cin = r_cin;
      end
      S_EXEC: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt   = 4'd0;
          w_res   = alu_RESULT;
          w_c     = alu_CARRY_OUT;
          w_v     = alu_OVERFLOW;
          w_h     = alu_HALFCARRY;
          w_state = w_bcd ? S_ADJUST : S_DONE;
          w_valid = !w_bcd;
        end else begin
          w_cnt     = r_cnt + 4'd1;
          w_alu_op  = r_alu_op;
          w_alu_cin = r_alu_cin;
        end
      end
      S_ADJUST: begin
        if (r_op == OP_ADD) begin
          if (r_h || (r_res[3:0] > 4'd9)) w_adj = w_adj | 8'h06;
          if (r_c || (r_res > 8'h99)) begin
            w_adj = w_adj | 8'h60;
            w_c   = 1'b1;
          end
          w_res = r_res + w_adj;
        end else begin
          // Subtraction borrows show up as a missing carry out of each nibble.
          if (!r_h) w_adj = w_adj | 8'h06;
          if (!r_c) w_adj = w_adj | 8'h60;
          w_res = r_res - w_adj;
        end
        w_state = S_DONE;
        w_valid = 1'b1;
      end
      S_DONE: begin
        if (result_READY) w_state = S_IDLE;
        else              w_valid = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_cin       <= 1'b0;
      r_dec       <= 1'b0;
      r_cnt       <= 4'd0;
      r_a_bus_en  <= 1'b0;
      r_a_zero_en <= 1'b0;
      r_b_en      <= 1'b0;
      r_b_inv_en  <= 1'b0;
      r_alu_op    <= 3'd0;
      r_alu_cin   <= 1'b0;
      r_res       <= 8'h00;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_h         <= 1'b0;
      r_err       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r_state     <= w_state;
      r_op        <= w_op;
      r_cin       <= w_cin;
      r_dec       <= w_dec;
      r_cnt       <= w_cnt;
      r_a_bus_en  <= w_a_bus_en;
      r_a_zero_en <= w_a_zero_en;
      r_b_en      <= w_b_en;
      r_b_inv_en  <= w_b_inv_en;
      r_alu_op    <= w_alu_op;
      r_alu_cin   <= w_alu_cin;
      r_res       <= w_res;
      r_c         <= w_c;
      r_v         <= w_v;
      r_h         <= w_h;
      r_err       <= w_err;
      r_valid     <= w_valid;
    end
  end

  assign req_READY           = (r_state == S_IDLE);
  assign aInput_systemBus_EN = r_a_bus_en;
  assign aInput_zero_EN      = r_a_zero_en;
  assign bInput_dataBus_EN   = r_b_en;
  assign bInput_invert_EN    = r_b_inv_en;
  assign alu_OP              = r_alu_op;
  assign alu_CARRY_IN        = r_alu_cin;
  assign result_DATA         = r_res;
  assign result_CARRY        = r_c;
  assign result_OVERFLOW     = r_v;
  assign result_ERROR        = r_err;
  assign result_VALID        = r_valid;

endmodule
